// File: rtl/core_pkg.sv
// rtl/core_pkg.sv - shared core phase constants, mem-stage FSM states and error codes
package core_pkg;

  localparam logic [2:0] ST_IF  = 3'd0;
  localparam logic [2:0] ST_ID  = 3'd1;
  localparam logic [2:0] ST_EX  = 3'd2;
  localparam logic [2:0] ST_MEM = 3'd3;
  localparam logic [2:0] ST_WB  = 3'd4;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2,
    HOLD   = 2'd3
  } mem_fsm_t;

  localparam logic [1:0] ERR_OK       = 2'b00;
  localparam logic [1:0] ERR_MISALIGN = 2'b01;
  localparam logic [1:0] ERR_RWCONF   = 2'b10;
  localparam logic [1:0] ERR_TIMEOUT  = 2'b11;

endpackage

// File: rtl/mem_access_if.sv
// rtl/mem_access_if.sv - data-memory req/ack bus between the mem stage and data memory
interface mem_access_if #(
  parameter int DMEM_AW = 16
);

  logic               dmem_req;
  logic               dmem_we;
  logic [DMEM_AW-1:0] dmem_addr;
  logic [31:0]        dmem_wdata;
  logic [31:0]        dmem_rdata;
  logic               dmem_ack;

  // mem stage side
  modport master (
    output dmem_req, dmem_we, dmem_addr, dmem_wdata,
    input  dmem_rdata, dmem_ack
  );

  // data memory side
  modport slave (
    input  dmem_req, dmem_we, dmem_addr, dmem_wdata,
    output dmem_rdata, dmem_ack
  );

endinterface

// File: rtl/mem_access.sv
// rtl/mem_access.sv - memory-access stage: one word load/store over req/ack, write-back hand-off
module mem_access
  import core_pkg::*;
#(
  parameter int DMEM_AW = 16,
  parameter int TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [2:0]  state,
  input  logic        mem_read_in,
  input  logic        mem_write_in,
  input  logic        reg_write_in,
  input  logic [4:0]  write_reg_in,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_write_data,
  input  logic [31:0] alu_data_in,
  mem_access_if.master dmem,
  output logic        reg_write_out,
  output logic [4:0]  write_reg_out,
  output logic [31:0] wb_data,
  output logic        done,
  output logic [1:0]  err
);

  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(TIMEOUT);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);

  mem_fsm_t           fsm_q, fsm_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic               req_q, req_d;
  logic               we_q, we_d;
  logic [DMEM_AW-1:0] addr_q, addr_d;
  logic [31:0]        wdata_q, wdata_d;
  logic               rw_lat_q, rw_lat_d;
  logic               reg_write_q, reg_write_d;
  logic [4:0]         write_reg_q, write_reg_d;
  logic [31:0]        wb_q, wb_d;
  logic [1:0]         err_q, err_d;

  logic unused_addr_hi;
  assign unused_addr_hi = &{1'b0, mem_addr[31:DMEM_AW+2]};

  // State and datapath registers; reset clears everything, dropping any in-flight request
  always_ff @(posedge clk) begin
    if (rst) begin
      fsm_q       <= IDLE;
      cnt_q       <= '0;
      req_q       <= 1'b0;
      we_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      rw_lat_q    <= 1'b0;
      reg_write_q <= 1'b0;
      write_reg_q <= '0;
      wb_q        <= '0;
      err_q       <= ERR_OK;
    end else begin
      fsm_q       <= fsm_d;
      cnt_q       <= cnt_d;
      req_q       <= req_d;
      we_q        <= we_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      rw_lat_q    <= rw_lat_d;
      reg_write_q <= reg_write_d;
      write_reg_q <= write_reg_d;
      wb_q        <= wb_d;
      err_q       <= err_d;
    end
  end

  // Next-state and next-output decode; the counter holds the number of request cycles so far
  always_comb begin
    fsm_d       = fsm_q;
    cnt_d       = cnt_q;
    req_d       = req_q;
    we_d        = we_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    rw_lat_d    = rw_lat_q;
    reg_write_d = reg_write_q;
    write_reg_d = write_reg_q;
    wb_d        = wb_q;
    err_d       = err_q;
    case (fsm_q)
      IDLE: begin
        if (state == ST_MEM) begin
          write_reg_d = write_reg_in;
          rw_lat_d    = reg_write_in;
          addr_d      = mem_addr[DMEM_AW+1:2];
          wdata_d     = mem_write_data;
          cnt_d       = '0;
          if (mem_read_in && mem_write_in) begin
            err_d       = ERR_RWCONF;
            reg_write_d = 1'b0;
            fsm_d       = DONE;
          end else if ((mem_read_in || mem_write_in) && (mem_addr[1:0] != 2'b00)) begin
            err_d       = ERR_MISALIGN;
            reg_write_d = 1'b0;
            fsm_d       = DONE;
          end else if (mem_read_in || mem_write_in) begin
            req_d       = 1'b1;
            we_d        = mem_write_in;
            cnt_d       = CNT_ONE;
            err_d       = ERR_OK;
            reg_write_d = 1'b0;
            fsm_d       = ACCESS;
          end else begin
            wb_d        = alu_data_in;
            reg_write_d = reg_write_in;
            err_d       = ERR_OK;
            fsm_d       = DONE;
          end
        end
      end
      ACCESS: begin
        if (dmem.dmem_ack) begin
          req_d = 1'b0;
          cnt_d = '0;
          if (we_q) begin
            reg_write_d = 1'b0;
          end else begin
            wb_d        = dmem.dmem_rdata;
            reg_write_d = rw_lat_q;
          end
          fsm_d = DONE;
        end else if (cnt_q == CNT_MAX) begin
          req_d       = 1'b0;
          cnt_d       = '0;
          err_d       = ERR_TIMEOUT;
          reg_write_d = 1'b0;
          fsm_d       = DONE;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      DONE: begin
        fsm_d = (state == ST_MEM) ? HOLD : IDLE;
      end
      HOLD: begin
        if (state != ST_MEM) fsm_d = IDLE;
      end
      default: fsm_d = IDLE;
    endcase
  end

  assign dmem.dmem_req   = req_q;
  assign dmem.dmem_we    = we_q;
  assign dmem.dmem_addr  = addr_q;
  assign dmem.dmem_wdata = wdata_q;
  assign reg_write_out   = reg_write_q;
  assign write_reg_out   = write_reg_q;
  assign wb_data         = wb_q;
  assign err             = err_q;
  assign done            = (fsm_q == DONE);

endmodule

// File: tb/tb_mem_access.sv
// tb/tb_mem_access.sv - randomized self-checking bench for mem_access against a transaction model
module tb_mem_access;

  localparam int AW = 16;
  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic [2:0]  state;
  logic        mem_read_in, mem_write_in, reg_write_in;
  logic [4:0]  write_reg_in;
  logic [31:0] mem_addr, mem_write_data, alu_data_in;
  logic        reg_write_out;
  logic [4:0]  write_reg_out;
  logic [31:0] wb_data;
  logic        done;
  logic [1:0]  err;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  mem_access_if #(.DMEM_AW(AW)) dmem ();

  mem_access #(.DMEM_AW(AW), .TIMEOUT(TO)) dut (
    .clk            (clk),
    .rst            (rst),
    .state          (state),
    .mem_read_in    (mem_read_in),
    .mem_write_in   (mem_write_in),
    .reg_write_in   (reg_write_in),
    .write_reg_in   (write_reg_in),
    .mem_addr       (mem_addr),
    .mem_write_data (mem_write_data),
    .alu_data_in    (alu_data_in),
    .dmem           (dmem.master),
    .reg_write_out  (reg_write_out),
    .write_reg_out  (write_reg_out),
    .wb_data        (wb_data),
    .done           (done),
    .err            (err)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_req"},   32'(dmem.dmem_req), 32'd0);
    check({tag, "_we"},    32'(dmem.dmem_we), 32'd0);
    check({tag, "_addr"},  32'(dmem.dmem_addr), 32'd0);
    check({tag, "_wdata"}, dmem.dmem_wdata, 32'd0);
    check({tag, "_rw"},    32'(reg_write_out), 32'd0);
    check({tag, "_wreg"},  32'(write_reg_out), 32'd0);
    check({tag, "_wb"},    wb_data, 32'd0);
    check({tag, "_done"},  32'(done), 32'd0);
    check({tag, "_err"},   32'(err), 32'd0);
  endtask

  // One stage transaction; ack_d = request cycle on which memory acks (outside 1..TO = never)
  task automatic run_op(input logic rd, input logic wr, input logic rw, input logic [4:0] wreg,
                        input logic [31:0] addr, input logic [31:0] wd, input logic [31:0] alu,
                        input logic [31:0] rdata, input int ack_d, input int keep3,
                        input bit drop_early);
    logic [1:0]  e_err;
    int          e_req;
    logic        e_rw;
    logic [31:0] e_wb;
    bit          chk_wb;
    int          req_n;
    int          done_n;
    int          done_k;
    logic [31:0] e_addr;
    e_addr = 32'(addr[AW+1:2]);
    e_wb   = 32'd0;
    chk_wb = 1'b0;
    if (rd && wr) begin
      e_err = 2'b10; e_req = 0; e_rw = 1'b0;
    end else if ((rd || wr) && addr[1:0] != 2'b00) begin
      e_err = 2'b01; e_req = 0; e_rw = 1'b0;
    end else if (rd || wr) begin
      if (ack_d >= 1 && ack_d <= TO) begin
        e_req = ack_d; e_err = 2'b00; e_rw = rd ? rw : 1'b0;
        e_wb = rdata; chk_wb = rd;
      end else begin
        e_req = TO; e_err = 2'b11; e_rw = 1'b0;
      end
    end else begin
      e_err = 2'b00; e_req = 0; e_rw = rw; e_wb = alu; chk_wb = 1'b1;
    end
    req_n = 0; done_n = 0; done_k = -1;
    @(posedge clk); #1;
    state = 3'd3; mem_read_in = rd; mem_write_in = wr; reg_write_in = rw;
    write_reg_in = wreg; mem_addr = addr; mem_write_data = wd; alu_data_in = alu;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      dmem.dmem_ack = 1'b0;
      if (dmem.dmem_req) begin
        req_n++;
        check("dmem_addr", 32'(dmem.dmem_addr), e_addr);
        check("dmem_we", 32'(dmem.dmem_we), 32'(wr));
        if (wr) check("dmem_wdata", dmem.dmem_wdata, wd);
        if (req_n == ack_d) begin
          dmem.dmem_ack = 1'b1;
          dmem.dmem_rdata = rdata;
        end
      end
      if (done) begin
        done_n++;
        if (done_k < 0) begin
          done_k = k;
          check("err", 32'(err), 32'(e_err));
          check("reg_write_out", 32'(reg_write_out), 32'(e_rw));
          if (chk_wb) begin
            check("wb_data", wb_data, e_wb);
            check("write_reg_out", 32'(write_reg_out), 32'(wreg));
          end
        end
      end
      if (done_k >= 0 && k > done_k) begin
        check("hold_err", 32'(err), 32'(e_err));
        check("hold_rw", 32'(reg_write_out), 32'(e_rw));
        if (chk_wb) check("hold_wb", wb_data, e_wb);
      end
      if (done_k >= 0 && k >= done_k + keep3) state = 3'd0;
      else if (drop_early && k >= 1) state = 3'd2;
      if (done_k >= 0 && k >= done_k + keep3 + 2) break;
    end
    dmem.dmem_ack = 1'b0;
    state = 3'd0;
    check("latency", 32'(done_k), 32'(e_req + 1));
    check("done_pulses", 32'(done_n), 32'd1);
    check("req_cycles", 32'(req_n), 32'(e_req));
  endtask

  initial begin
    rst = 1'b1; state = 3'd0;
    mem_read_in = 1'b0; mem_write_in = 1'b0; reg_write_in = 1'b0; write_reg_in = 5'd0;
    mem_addr = 32'd0; mem_write_data = 32'd0; alu_data_in = 32'd0;
    dmem.dmem_ack = 1'b0; dmem.dmem_rdata = 32'd0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_all_zero("reset");
    rst = 1'b0;

    run_op(1'b0, 1'b0, 1'b1, 5'd1, 32'd0,   32'd0,  32'd13, 32'd0,          0, 0, 1'b0);
    run_op(1'b1, 1'b0, 1'b1, 5'd2, 32'd36,  32'd0,  32'd0,  32'hDEADBEEF,   2, 0, 1'b0);
    run_op(1'b0, 1'b1, 1'b0, 5'd0, 32'd148, 32'd11, 32'd0,  32'd0,          3, 0, 1'b0);
    run_op(1'b1, 1'b0, 1'b1, 5'd3, 32'd38,  32'd0,  32'd0,  32'd0,          1, 0, 1'b0);
    run_op(1'b1, 1'b1, 1'b1, 5'd4, 32'd40,  32'd5,  32'd0,  32'd0,          1, 0, 1'b0);
    run_op(1'b1, 1'b0, 1'b1, 5'd6, 32'd40,  32'd0,  32'd0,  32'h12345678,   0, 0, 1'b0);
    run_op(1'b1, 1'b0, 1'b1, 5'd7, 32'd44,  32'd0,  32'd0,  32'hCAFEF00D,  TO, 0, 1'b0);
    run_op(1'b1, 1'b0, 1'b1, 5'd8, 32'd48,  32'd0,  32'd0,  32'h0BADF00D,   2, 0, 1'b1);
    run_op(1'b0, 1'b0, 1'b1, 5'd0, 32'd0,   32'd0,  32'd21, 32'd0,          0, 10, 1'b0);
    run_op(1'b0, 1'b0, 1'b1, 5'd5, 32'd0,   32'd0,  32'd77, 32'd0,          0, 0, 1'b0);

    for (int i = 0; i < 40; i++) begin
      logic        r_rd, r_wr;
      logic [31:0] r_addr;
      r_rd = ($urandom_range(0, 2) == 0);
      r_wr = ($urandom_range(0, 2) == 0);
      r_addr = $urandom;
      if ($urandom_range(0, 3) != 0) r_addr[1:0] = 2'b00;
      run_op(r_rd, r_wr, 1'($urandom), 5'($urandom), r_addr, $urandom, $urandom, $urandom,
             int'($urandom_range(0, 6)), int'($urandom_range(0, 3)), 1'($urandom));
    end

    @(posedge clk); #1;
    state = 3'd3; mem_read_in = 1'b1; mem_write_in = 1'b0; reg_write_in = 1'b1;
    write_reg_in = 5'd9; mem_addr = 32'd52; alu_data_in = 32'd3;
    @(negedge clk);
    @(negedge clk);
    check("rst_pre_req", 32'(dmem.dmem_req), 32'd1);
    @(negedge clk);
    rst = 1'b1; state = 3'd0;
    @(negedge clk);
    check_all_zero("rst_mid");
    rst = 1'b0;
    dmem.dmem_ack = 1'b1; dmem.dmem_rdata = 32'hFFFF0000;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      dmem.dmem_ack = 1'b0;
      check("late_ack_done", 32'(done), 32'd0);
      check("late_ack_req", 32'(dmem.dmem_req), 32'd0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
